eda_mask_buffer: RTL

Full-image regional-maximum mask store for the imregionalmax datapath. Holds one bit per image pixel (1 = still a maximum candidate) and accepts window-sized clear updates at arbitrary (i, j) offsets from the compare stage, ignoring window pixels that overhang the image edge. A readout state machine streams the finished mask one image row per beat over a valid/ready handshake, replacing the fixed single-window output matrix of the previous generation.

---
 rtl/eda_mask_buffer_pkg.sv | 17 +
 rtl/eda_mask_window_decode.sv | 53 +++++
 rtl/eda_mask_buffer.sv | 115 +++++++++++
 3 files changed

// File: rtl/eda_mask_buffer_pkg.sv
// Shared configuration and FSM state encoding for the regional-maximum mask store.
package eda_mask_buffer_pkg;

    localparam int CFG_IMG_ROWS = 16;
    localparam int CFG_IMG_COLS = 16;
    localparam int CFG_M        = 3;
    localparam int CFG_N        = 3;
    localparam int CFG_I_WIDTH  = $clog2(CFG_IMG_ROWS);
    localparam int CFG_J_WIDTH  = $clog2(CFG_IMG_COLS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/eda_mask_window_decode.sv
// Maps a window clear strobe at offset (upd_i, upd_j) onto per-pixel clear enables.
// Pixels that overhang the image edge simply match no image position.
module eda_mask_window_decode
    import eda_mask_buffer_pkg::*;
#(
    parameter int IMG_ROWS = CFG_IMG_ROWS,
    parameter int IMG_COLS = CFG_IMG_COLS,
    parameter int M        = CFG_M,
    parameter int N        = CFG_N,
    parameter int I_WIDTH  = CFG_I_WIDTH,
    parameter int J_WIDTH  = CFG_J_WIDTH
) (
    input  logic [I_WIDTH-1:0]                upd_i,
    input  logic [J_WIDTH-1:0]                upd_j,
    input  logic [M-1:0][N-1:0]               strb_value,
    output logic [IMG_ROWS-1:0][IMG_COLS-1:0] clr_en
);

    localparam int ROW_W = I_WIDTH + 1;
    localparam int COL_W = J_WIDTH + 1;

    // One extra bit so targets past the last row/column never alias back to 0.
    logic [ROW_W-1:0] tgt_row [M];
    logic [COL_W-1:0] tgt_col [N];

    for (genvar gi = 0; gi < M; gi++) begin : g_tgt_row
        assign tgt_row[gi] = {1'b0, upd_i} + ROW_W'(gi);
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_tgt_col
        assign tgt_col[gi] = {1'b0, upd_j} + COL_W'(gi);
    end

    for (genvar gi = 0; gi < IMG_ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < IMG_COLS; gj++) begin : g_col
            logic hit;
            always_comb begin
                hit = 1'b0;
                for (int wr = 0; wr < M; wr++) begin
                    for (int wc = 0; wc < N; wc++) begin
                        if (strb_value[wr][wc] &&
                            (tgt_row[wr] == ROW_W'(gi)) &&
                            (tgt_col[wc] == COL_W'(gj))) begin
                            hit = 1'b1;
                        end
                    end
                end
            end
            assign clr_en[gi][gj] = hit;
        end
    end

endmodule

// File: rtl/eda_mask_buffer.sv
// Full-image regional-maximum mask with window clear updates and a row-per-beat
// readout stream over valid/ready.
module eda_mask_buffer
    import eda_mask_buffer_pkg::*;
#(
    parameter int IMG_ROWS = CFG_IMG_ROWS,
    parameter int IMG_COLS = CFG_IMG_COLS,
    parameter int M        = CFG_M,
    parameter int N        = CFG_N,
    parameter int I_WIDTH  = CFG_I_WIDTH,
    parameter int J_WIDTH  = CFG_J_WIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [I_WIDTH-1:0]  upd_i,
    input  logic [J_WIDTH-1:0]  upd_j,
    input  logic                compare_out,
    input  logic [M-1:0][N-1:0] strb_value,
    input  logic                rd_start,
    output logic                busy,
    output logic                row_valid,
    input  logic                row_ready,
    output logic [IMG_COLS-1:0] row_data,
    output logic                row_last,
    output logic                done
);

    logic [IMG_ROWS-1:0][IMG_COLS-1:0] mask_q, mask_d;
    logic [IMG_ROWS-1:0][IMG_COLS-1:0] clr_en;
    state_e                            state_q, state_d;
    logic [I_WIDTH-1:0]                row_cnt_q, row_cnt_d;
    logic                              upd_fire;
    logic                              last_row;

    eda_mask_window_decode #(
        .IMG_ROWS (IMG_ROWS),
        .IMG_COLS (IMG_COLS),
        .M        (M),
        .N        (N),
        .I_WIDTH  (I_WIDTH),
        .J_WIDTH  (J_WIDTH)
    ) u_decode (
        .upd_i      (upd_i),
        .upd_j      (upd_j),
        .strb_value (strb_value),
        .clr_en     (clr_en)
    );

    assign upd_ready = (state_q == ST_IDLE) && !clear;
    assign upd_fire  = upd_valid && upd_ready && !compare_out;
    assign last_row  = (row_cnt_q == I_WIDTH'(IMG_ROWS - 1));

    assign busy      = (state_q == ST_STREAM);
    assign row_valid = (state_q == ST_STREAM);
    assign row_last  = (state_q == ST_STREAM) && last_row;
    assign done      = (state_q == ST_DONE);
    assign row_data  = mask_q[row_cnt_q];

    always_comb begin
        mask_d    = mask_q;
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        if (clear) begin
            mask_d    = '1;
            state_d   = ST_IDLE;
            row_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Update and rd_start may coincide; the first beat then sees the new mask.
                    if (upd_fire) begin
                        mask_d = mask_q & ~clr_en;
                    end
                    if (rd_start) begin
                        state_d   = ST_STREAM;
                        row_cnt_d = '0;
                    end
                end
                ST_STREAM: begin
                    if (row_ready) begin
                        if (last_row) begin
                            state_d = ST_DONE;
                        end else begin
                            row_cnt_d = row_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d   = ST_IDLE;
                    row_cnt_d = '0;
                end
                default: begin
                    state_d   = ST_IDLE;
                    row_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q    <= '1;
            state_q   <= ST_IDLE;
            row_cnt_q <= '0;
        end else begin
            mask_q    <= mask_d;
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
        end
    end

endmodule
